// File: rtl/dsp_mul_seq.sv
// Purpose: sequential RV32M multiplier (MUL/MULH/MULHSU/MULHU) built from 16x16 partial products.
// Latency: done pulses 6 cycles after an accepted start; one operation per 7 cycles.
// Backpressure: start is sampled only in IDLE and ignored otherwise; busy stalls the pipeline.
// Optional: define MUL_EARLY_ZERO_EN to short-circuit zero operands straight to DONE (done at t1).
module dsp_mul_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int HALF = XLEN / 2;
    localparam int ACCW = 2 * XLEN;

    // RV32M funct3[1:0] encodings
    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PP   = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [1:0]      cnt;
    logic [1:0]      op_q;
    logic            neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [ACCW-1:0] acc;

    // operand conditioning: signedness per op, conversion to magnitude
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            zero_operand;

    // partial product datapath (single 16x16 multiplier, operands muxed by cnt)
    logic [HALF-1:0] pp_a;
    logic [HALF-1:0] pp_b;
    logic [XLEN-1:0] pp;
    logic [ACCW-1:0] pp_shifted;
    logic [ACCW-1:0] acc_fixed;
    logic [XLEN-1:0] acc_word;

    // Sign handling: a is signed for MULH/MULHSU, b only for MULH; magnitudes fed to the array.
    always_comb begin
        a_signed     = (op == OP_MULH) || (op == OP_MULHSU);
        b_signed     = (op == OP_MULH);
        sa           = a_signed && in_a[XLEN-1];
        sb           = b_signed && in_b[XLEN-1];
        a_abs        = sa ? (~in_a + 1'b1) : in_a;
        b_abs        = sb ? (~in_b + 1'b1) : in_b;
        zero_operand = (in_a == '0) || (in_b == '0);
    end

    // Select the half-word pair and alignment for the current partial product.
    always_comb begin
        pp_a       = a_mag[HALF-1:0];
        pp_b       = b_mag[HALF-1:0];
        pp_shifted = '0;
        case (cnt)
            2'd0: begin
                pp_a = a_mag[HALF-1:0];
                pp_b = b_mag[HALF-1:0];
            end
            2'd1: begin
                pp_a = a_mag[XLEN-1:HALF];
                pp_b = b_mag[HALF-1:0];
            end
            2'd2: begin
                pp_a = a_mag[HALF-1:0];
                pp_b = b_mag[XLEN-1:HALF];
            end
            default: begin
                pp_a = a_mag[XLEN-1:HALF];
                pp_b = b_mag[XLEN-1:HALF];
            end
        endcase
        pp = pp_a * pp_b;
        case (cnt)
            2'd0:    pp_shifted = {{XLEN{1'b0}}, pp};
            2'd1,
            2'd2:    pp_shifted = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
            default: pp_shifted = {pp, {XLEN{1'b0}}};
        endcase
    end

    // Final two's-complement fix-up of the magnitude product and low/high word pick.
    always_comb begin
        acc_fixed = neg ? (~acc + 1'b1) : acc;
        acc_word  = (op_q == OP_MUL) ? acc_fixed[XLEN-1:0] : acc_fixed[ACCW-1:XLEN];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE -> PP x4 -> SIGN -> DONE -> IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MUL_EARLY_ZERO_EN
                    state_next = zero_operand ? DONE : PP;
`else
                    state_next = PP;
`endif
                end
            end
            PP:      state_next = (cnt == 2'd3) ? SIGN : PP;
            SIGN:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Datapath: capture on accept, accumulate partial products, fix sign, latch result.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            cnt    <= 2'd0;
            op_q   <= 2'd0;
            neg    <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        neg   <= sa ^ sb;
                        a_mag <= a_abs;
                        b_mag <= b_abs;
                        acc   <= '0;
                        cnt   <= 2'd0;
`ifdef MUL_EARLY_ZERO_EN
                        // zero product skips the array; result is visible with done at t1
                        if (zero_operand) begin
                            result <= '0;
                        end
`endif
                    end
                end
                PP: begin
                    acc <= acc + pp_shifted;
                    cnt <= cnt + 2'd1;
                end
                SIGN: begin
                    acc    <= acc_fixed;
                    result <= acc_word;
                end
                default: begin
                end
            endcase
        end
    end

    // zero_operand only steers the FSM when the early-zero path is built in
    logic unused_ok;
    assign unused_ok = zero_operand;

endmodule

// File: tb/tb_dsp_mul_seq.sv
// Purpose: self-checking bench for dsp_mul_seq against an arithmetic reference model.
// Latency: expects done exactly 6 cycles after accept (1 for zero operands with MUL_EARLY_ZERO_EN).
// Backpressure: checks that start is ignored while busy and in the done cycle.
module tb_dsp_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    dsp_mul_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .in_a   (in_a),
        .in_b   (in_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: full 64-bit product of sign- or zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] mop, input logic [31:0] a, input logic [31:0] b);
        longint ea;
        longint eb;
        longint p;
        ea = (mop == 2'b01 || mop == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
        eb = (mop == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
        p  = ea * eb;
        return (mop == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic int latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_EARLY_ZERO_EN
        return (a == 32'd0 || b == 32'd0) ? 1 : 6;
`else
        if (a == 32'd0 || b == 32'd0) return 6;
        return 6;
`endif
    endfunction

    // Issue one op from the current cycle (t0) and check busy/done/result each cycle to t_lat+1.
    task automatic run_op(input string tag, input logic [1:0] mop, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int lat);
        start = 1'b1;
        op    = mop;
        in_a  = a;
        in_b  = b;
        step();
        start = 1'b0;
        for (int c = 1; c <= lat; c++) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy t%0d: got %b want 1", tag, c, busy);
            end
            checks++;
            if (done !== (c == lat)) begin
                errors++;
                $display("FAIL %s done t%0d: got %b want %b", tag, c, done, (c == lat));
            end
            if (c == lat) begin
                checks++;
                if (result !== exp_res) begin
                    errors++;
                    $display("FAIL %s result: got %h want %h (op %0d a %h b %h)", tag, result, exp_res, mop, a, b);
                end
            end
            step();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s idle after done: busy %b done %b want 0 0", tag, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        in_a  = 32'd0;
        in_b  = 32'd0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy %b done %b result %h want 0 0 0", busy, done, result);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle: busy %b done %b result %h want 0 0 0", busy, done, result);
        end
    endtask

    task automatic test_directed();
        run_op("mul_7x6",      2'b00, 32'd7,        32'd6,        32'h0000002A, 6);
        run_op("mulhu_ff",     2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 6);
        run_op("mul_ff",       2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 6);
        run_op("mulh_min",     2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 6);
        run_op("mulhsu_ff",    2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 6);
        run_op("mulh_m1x2",    2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 6);
        run_op("mul_zero",     2'b00, 32'd0,        32'hDEADBEEF, 32'h00000000, latency(32'd0, 32'hDEADBEEF));
        run_op("mulhu_zero_b", 2'b11, 32'h12345678, 32'd0,        32'h00000000, latency(32'h12345678, 32'd0));
        step();
    endtask

    // start pulsed while busy (t2) and in the done cycle (t6) must be ignored.
    task automatic test_start_ignored();
        start = 1'b1;
        op    = 2'b00;
        in_a  = 32'd3;
        in_b  = 32'd5;
        step();
        for (int c = 1; c <= 6; c++) begin
            start = (c == 2 || c == 6);
            if (start) begin
                in_a = 32'd9;
                in_b = 32'd9;
            end
            checks++;
            if (done !== (c == 6) || busy !== 1'b1) begin
                errors++;
                $display("FAIL ign_start t%0d: done %b busy %b want %b 1", c, done, busy, (c == 6));
            end
            if (c == 6) begin
                checks++;
                if (result !== 32'h0000000F) begin
                    errors++;
                    $display("FAIL ign_start result: got %h want 0000000f", result);
                end
            end
            step();
        end
        start = 1'b0;
        for (int c = 7; c <= 12; c++) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000000F) begin
                errors++;
                $display("FAIL ign_start t%0d: busy %b done %b result %h want 0 0 0000000f", c, busy, done, result);
            end
            step();
        end
    endtask

    // Reset asserted at t3 aborts the op with no done pulse; a fresh op then works.
    task automatic test_reset_mid();
        start = 1'b1;
        op    = 2'b00;
        in_a  = 32'h1234;
        in_b  = 32'h10;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || result !== 32'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid t4: busy %b result %h done %b want 0 0 0", busy, result, done);
        end
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid stray: done %b busy %b want 0 0", done, busy);
            end
            step();
        end
        run_op("after_reset_2x2", 2'b00, 32'd2, 32'd2, 32'h00000004, 6);
    endtask

    // Random ops issued back to back (start in the cycle after done) or with idle gaps.
    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  mop;
        for (int n = 0; n < 48; n++) begin
            case ($urandom_range(0, 5))
                0:       a = 32'd0;
                1:       a = 32'h80000000;
                2:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'h80000000;
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            mop = 2'($urandom_range(0, 3));
            run_op("random", mop, a, b, model(mop, a, b), latency(a, b));
            if ($urandom_range(0, 2) == 0) begin
                step();
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
